// File: rtl/fortune_reader.sv
// rtl/fortune_reader.sv - reads one zero-terminated fortune from a synchronous RAM and streams it out

module fortune_reader #(
    parameter int MAX_LEN = 8,
    parameter int DATA_W  = 7,
    localparam int OFF_W  = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [7-OFF_W:0]   index,
    input  logic               ready,
    output logic [7:0]         mem_addr,
    input  logic [DATA_W-1:0]  mem_q,
    output logic [DATA_W-1:0]  char_out,
    output logic               char_valid,
    output logic               busy,
    output logic               done,
    output logic [OFF_W:0]     count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        FETCH = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MAX_LEN - 1);

    state_t             state;
    state_t             state_next;
    logic [OFF_W-1:0]   offset;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            mem_addr   <= '0;
            offset     <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            count      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= {index, {OFF_W{1'b0}}};
                        offset   <= '0;
                        count    <= '0;
                    end
                end
                FETCH: begin
                    if (mem_q != '0) begin
                        char_out   <= mem_q;
                        char_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (ready) begin
                        char_valid <= 1'b0;
                        count      <= count + 1'b1;
                        // The last slot ends the fortune without stepping into the next block
                        if (offset != LAST_OFF) begin
                            offset   <= offset + OFF_W'(1);
                            mem_addr <= mem_addr + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = (mem_q == '0) ? DONE : OUT;
            end
            OUT: begin
                busy = 1'b1;
                if (ready) state_next = (offset == LAST_OFF) ? DONE : WAIT;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
